// File: rtl/mm_bridge_pkg.sv
// Shared constants, FSM state encoding and byte-select helper for the
// memory-mapped host bridge.
package mm_bridge_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK  = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h45;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_WR_STROBE,
        ST_RD_STROBE,
        ST_RD_WAIT,
        ST_SEND
    } state_t;

    // Byte idx of a word, idx 0 being the most significant byte.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    word_byte = w[31:24];
            2'd1:    word_byte = w[23:16];
            2'd2:    word_byte = w[15:8];
            default: word_byte = w[7:0];
        endcase
    endfunction

endpackage

// File: rtl/mm_host_bridge_frame_timeout.sv
// Inter-byte idle counter: counts cycles while run is high, restarts on clear,
// and pulses expired on the cycle that completes TIMEOUT_CYCLES idle cycles.
module frame_timeout #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    assign expired = run && !clear && (count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || clear || !run || expired)
            count <= '0;
        else
            count <= count + 1'b1;
    end

endmodule

// File: rtl/mm_host_bridge.sv
// Byte-stream to memory-mapped register bridge: decodes write/read frames,
// issues single-cycle strobes and streams back an ack, error or read word.
module mm_host_bridge
    import mm_bridge_pkg::*;
#(
    parameter int READ_LATENCY   = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        mm_write_en,
    output logic        mm_read_en,
    output logic [7:0]  mm_addr,
    output logic [31:0] mm_wdata,
    input  logic [31:0] mm_rdata,
    output logic        busy
);

    localparam int LW = $clog2(READ_LATENCY + 1);

    state_t        state, state_nxt;
    logic          rx_fire, tx_fire;
    logic          op_read;
    logic [7:0]    addr_sh;
    logic [23:0]   wdata_sh;
    logic [1:0]    byte_cnt;
    logic [1:0]    tx_idx, tx_last;
    logic [31:0]   rsp_word;
    logic [LW-1:0] lat_cnt;
    logic          lat_done;
    logic          expired;
    logic          in_frame;

    assign in_frame    = (state == ST_GET_ADDR) || (state == ST_GET_DATA);
    assign rx_ready    = !rst && ((state == ST_IDLE) || in_frame);
    assign rx_fire     = rx_valid && rx_ready;
    assign tx_fire     = tx_valid && tx_ready;
    assign mm_write_en = (state == ST_WR_STROBE);
    assign mm_read_en  = (state == ST_RD_STROBE);
    assign busy        = (state != ST_IDLE);
    assign lat_done    = (state == ST_RD_WAIT) && (lat_cnt == LW'(READ_LATENCY - 1));

    frame_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .run    (in_frame),
        .clear  (rx_fire),
        .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:
                if (rx_fire)
                    state_nxt = (rx_data == OP_WRITE || rx_data == OP_READ) ? ST_GET_ADDR : ST_SEND;
            ST_GET_ADDR:
                if (rx_fire)
                    state_nxt = op_read ? ST_RD_STROBE : ST_GET_DATA;
                else if (expired)
                    state_nxt = ST_SEND;
            ST_GET_DATA:
                if (rx_fire && byte_cnt == 2'd3)
                    state_nxt = ST_WR_STROBE;
                else if (expired)
                    state_nxt = ST_SEND;
            ST_WR_STROBE: state_nxt = ST_SEND;
            ST_RD_STROBE: state_nxt = ST_RD_WAIT;
            ST_RD_WAIT:
                if (lat_done)
                    state_nxt = ST_SEND;
            ST_SEND:
                if (tx_fire && tx_idx == tx_last)
                    state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Frame assembly happens in shadow registers so an aborted frame never
    // disturbs the bus-visible address and data.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_read  <= 1'b0;
            addr_sh  <= '0;
            wdata_sh <= '0;
            byte_cnt <= '0;
            mm_addr  <= '0;
            mm_wdata <= '0;
            lat_cnt  <= '0;
            rsp_word <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            tx_idx   <= '0;
            tx_last  <= '0;
        end else begin
            case (state)
                ST_IDLE:
                    if (rx_fire) begin
                        op_read <= (rx_data == OP_READ);
                        if (rx_data != OP_WRITE && rx_data != OP_READ) begin
                            tx_data  <= RSP_ERR;
                            tx_valid <= 1'b1;
                            tx_idx   <= '0;
                            tx_last  <= '0;
                        end
                    end
                ST_GET_ADDR:
                    if (rx_fire) begin
                        addr_sh  <= rx_data;
                        byte_cnt <= '0;
                        if (op_read)
                            mm_addr <= rx_data;
                    end else if (expired) begin
                        tx_data  <= RSP_ERR;
                        tx_valid <= 1'b1;
                        tx_idx   <= '0;
                        tx_last  <= '0;
                    end
                ST_GET_DATA:
                    if (rx_fire) begin
                        wdata_sh <= {wdata_sh[15:0], rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            mm_wdata <= {wdata_sh, rx_data};
                            mm_addr  <= addr_sh;
                        end
                    end else if (expired) begin
                        tx_data  <= RSP_ERR;
                        tx_valid <= 1'b1;
                        tx_idx   <= '0;
                        tx_last  <= '0;
                    end
                ST_WR_STROBE: begin
                    tx_data  <= RSP_ACK;
                    tx_valid <= 1'b1;
                    tx_idx   <= '0;
                    tx_last  <= '0;
                end
                ST_RD_STROBE: lat_cnt <= '0;
                ST_RD_WAIT:
                    if (lat_done) begin
                        rsp_word <= mm_rdata;
                        tx_data  <= mm_rdata[31:24];
                        tx_valid <= 1'b1;
                        tx_idx   <= '0;
                        tx_last  <= 2'd3;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                ST_SEND:
                    if (tx_fire) begin
                        if (tx_idx == tx_last) begin
                            tx_valid <= 1'b0;
                        end else begin
                            tx_idx  <= tx_idx + 2'd1;
                            tx_data <= word_byte(rsp_word, tx_idx + 2'd1);
                        end
                    end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mm_host_bridge.sv
// Directed bench for mm_host_bridge: queue-based model of expected bus
// operations and response bytes, checked every cycle by a monitor process.
module tb_mm_host_bridge;

    localparam int RL = 2;
    localparam int T  = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        mm_write_en;
    logic        mm_read_en;
    logic [7:0]  mm_addr;
    logic [31:0] mm_wdata;
    logic [31:0] mm_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_tx[$];
    logic [39:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic [31:0] rd_val = 32'h0;

    always #5 clk = ~clk;

    mm_host_bridge #(
        .READ_LATENCY  (RL),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .mm_write_en(mm_write_en),
        .mm_read_en (mm_read_en),
        .mm_addr    (mm_addr),
        .mm_wdata   (mm_wdata),
        .mm_rdata   (mm_rdata),
        .busy       (busy)
    );

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Slave model: read data is valid only in the cycle before the capture
    // edge, RL edges after the edge that samples mm_read_en.
    initial begin
        int  cd = 0;
        logic rd_s;
        mm_rdata = 32'hDEADBEEF;
        forever begin
            @(negedge clk);
            rd_s = mm_read_en;
            @(posedge clk);
            #1;
            cd = rd_s ? RL : ((cd > 0) ? cd - 1 : 0);
            mm_rdata = (cd == 1) ? rd_val : 32'hDEADBEEF;
        end
    end

    // Monitor: every bus strobe and every tx transfer is matched against the model queues.
    initial begin
        bit         prev_wr = 0, prev_rd = 0, prev_hold = 0;
        logic [7:0] prev_data = 0;
        forever begin
            @(negedge clk);
            if (mm_write_en && mm_read_en)
                chk(0, "both_strobes", 32'h3, 32'h0);
            if (mm_write_en) begin
                if (prev_wr) chk(0, "wr_pulse_width", 32'd2, 32'd1);
                if (exp_wr.size() == 0) chk(0, "unexpected_write", {24'h0, mm_addr}, 32'h0);
                else begin
                    chk(mm_addr == exp_wr[0][39:32], "wr_addr", {24'h0, mm_addr}, {24'h0, exp_wr[0][39:32]});
                    chk(mm_wdata == exp_wr[0][31:0], "wr_data", mm_wdata, exp_wr[0][31:0]);
                    void'(exp_wr.pop_front());
                end
            end
            if (mm_read_en) begin
                if (prev_rd) chk(0, "rd_pulse_width", 32'd2, 32'd1);
                if (exp_rd.size() == 0) chk(0, "unexpected_read", {24'h0, mm_addr}, 32'h0);
                else begin
                    chk(mm_addr == exp_rd[0], "rd_addr", {24'h0, mm_addr}, {24'h0, exp_rd[0]});
                    void'(exp_rd.pop_front());
                end
            end
            if (prev_hold && !rst)
                chk(tx_valid && tx_data == prev_data, "tx_stable", {23'h0, tx_valid, tx_data}, {23'h0, 1'b1, prev_data});
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) chk(0, "unexpected_tx", {24'h0, tx_data}, 32'h0);
                else begin
                    chk(tx_data == exp_tx[0], "tx_byte", {24'h0, tx_data}, {24'h0, exp_tx[0]});
                    void'(exp_tx.pop_front());
                end
            end
            prev_wr   = mm_write_en;
            prev_rd   = mm_read_en;
            prev_hold = tx_valid && !tx_ready && !rst;
            prev_data = tx_data;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit got = 0;
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rx_ready) begin
                got = 1;
                break;
            end
        end
        chk(got, "rx_accept", {31'h0, got}, 32'h1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (exp_tx.size() == 0 && !busy) break;
        end
        chk(exp_tx.size() == 0 && !busy, "drain", exp_tx.size(), 32'h0);
    endtask

    task automatic write_frame(input logic [7:0] a, input logic [31:0] d);
        exp_wr.push_back({a, d});
        exp_tx.push_back(8'h4B);
        send_byte(8'h57);
        send_byte(a);
        for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
    endtask

    task automatic read_frame(input logic [7:0] a, input logic [31:0] v);
        rd_val = v;
        exp_rd.push_back(a);
        for (int i = 3; i >= 0; i--) exp_tx.push_back(v[8*i +: 8]);
        send_byte(8'h52);
        send_byte(a);
    endtask

    initial begin
        int cnt;
        int seen;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk(rx_ready == 0, "rst_rx_ready", {31'h0, rx_ready}, 32'h0);
        chk(tx_valid == 0 && tx_data == 0, "rst_tx", {23'h0, tx_valid, tx_data}, 32'h0);
        chk(!mm_write_en && !mm_read_en && !busy, "rst_ctrl", {29'h0, mm_write_en, mm_read_en, busy}, 32'h0);
        chk(mm_addr == 0 && mm_wdata == 0, "rst_bus", mm_wdata | {24'h0, mm_addr}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk(rx_ready == 1, "rx_ready_after_rst", {31'h0, rx_ready}, 32'h1);

        // Write frame with literal timing expectations.
        exp_wr.push_back({8'h00, 32'h00001EB5});
        exp_tx.push_back(8'h4B);
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h1E); send_byte(8'hB5);
        @(negedge clk);
        chk(mm_write_en == 1, "wr_strobe_cycle", {31'h0, mm_write_en}, 32'h1);
        chk(mm_wdata == 32'h00001EB5, "wr_wdata_lit", mm_wdata, 32'h00001EB5);
        chk(mm_addr == 8'h00 && busy, "wr_addr_busy", {23'h0, busy, mm_addr}, 32'h100);
        @(negedge clk);
        chk(tx_valid && tx_data == 8'h4B, "ack_next_cycle", {23'h0, tx_valid, tx_data}, 32'h14B);
        chk(mm_write_en == 0, "wr_strobe_drop", {31'h0, mm_write_en}, 32'h0);
        wait_drain(50);

        // Read frame: tx_valid rises RL+1 cycles after the address byte.
        read_frame(8'h02, 32'h05030104);
        @(negedge clk);
        chk(mm_read_en == 1 && mm_addr == 8'h02, "rd_strobe_cycle", {23'h0, mm_read_en, mm_addr}, 32'h102);
        cnt = 1;
        while (!tx_valid && cnt < 20) begin
            @(negedge clk);
            if (!tx_valid) cnt++;
        end
        chk(cnt == RL + 1, "rd_latency", cnt, RL + 1);
        chk(tx_data == 8'h05, "rd_first_byte_lit", {24'h0, tx_data}, 32'h05);
        wait_drain(50);

        // Invalid opcode, then a normal write.
        exp_tx.push_back(8'h45);
        send_byte(8'h33);
        wait_drain(50);
        write_frame(8'h05, 32'hA55A00FF);
        wait_drain(50);
        chk(mm_addr == 8'h05 && mm_wdata == 32'hA55A00FF, "bus_hold", mm_wdata, 32'hA55A00FF);

        // Truncated frame times out with an error byte and no bus access.
        exp_tx.push_back(8'h45);
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h12);
        cnt = 0;
        for (int k = 0; k < T + 20; k++) begin
            @(negedge clk);
            if (tx_valid) break;
            cnt++;
        end
        chk(cnt == T, "timeout_cycles", cnt, T);
        wait_drain(50);
        chk(mm_addr == 8'h05 && mm_wdata == 32'hA55A00FF, "partial_discarded", mm_wdata, 32'hA55A00FF);
        read_frame(8'h10, 32'hFFFF0000);
        wait_drain(50);

        // Back-pressure during a read response, then reset mid-response.
        tx_ready = 1'b0;
        read_frame(8'h03, 32'h12345678);
        for (int k = 0; k < 20 && !tx_valid; k++) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk(tx_valid && tx_data == 8'h12, "hold_data", {23'h0, tx_valid, tx_data}, 32'h112);
            chk(rx_ready == 0, "hold_rx_ready", {31'h0, rx_ready}, 32'h0);
        end
        @(posedge clk); #1 tx_ready = 1'b1;
        @(posedge clk); #1 tx_ready = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk(!tx_valid && tx_data == 0, "mid_rst_tx", {23'h0, tx_valid, tx_data}, 32'h0);
        chk(!mm_write_en && !mm_read_en && !busy && !rx_ready, "mid_rst_ctrl",
            {28'h0, mm_write_en, mm_read_en, busy, rx_ready}, 32'h0);
        chk(mm_addr == 0 && mm_wdata == 0, "mid_rst_bus", mm_wdata | {24'h0, mm_addr}, 32'h0);
        exp_tx.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        tx_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (tx_valid || mm_write_en || mm_read_en) seen++;
        end
        chk(seen == 0, "quiet_after_rst", seen, 32'h0);
        chk(exp_wr.size() == 0 && exp_rd.size() == 0, "bus_ops_seen", exp_wr.size() + exp_rd.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
